// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl
//   APB initiator for the ALU CSR slave. Takes one command at a time on a
//   valid/ready interface, runs a SETUP/ACCESS transfer, waits for PREADY
//   with a bounded timeout, and holds the result on a response interface
//   until it is consumed.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   cmd_valid/ready command handshake; cmd_write/addr/wdata describe the access
//   rsp_valid/ready response handshake; rsp_rdata/err/timeout carry the result
//   sel, en, write, addr, wdata   APB PSEL/PENABLE/PWRITE/PADDR/PWDATA
//   ready, slv_err, rdata         APB PREADY/PSLVERR/PRDATA
module apb_master_ctrl #(
   parameter int unsigned ADDR_WIDTH     = 3,
   parameter int unsigned APB_BUS_SIZE   = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [APB_BUS_SIZE-1:0] cmd_wdata,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [APB_BUS_SIZE-1:0] rsp_rdata,
   output logic                    rsp_err,
   output logic                    rsp_timeout,
   output logic                    sel,
   output logic                    en,
   output logic                    write,
   output logic [ADDR_WIDTH-1:0]   addr,
   output logic [APB_BUS_SIZE-1:0] wdata,
   input  logic                    ready,
   input  logic                    slv_err,
   input  logic [APB_BUS_SIZE-1:0] rdata
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

   // Gated with rst_n so cmd_ready reads 0 while reset is held, even though
   // the state register already sits in IDLE.
   assign cmd_ready = rst_n & (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         sel         <= 1'b0;
         en          <= 1'b0;
         write       <= 1'b0;
         addr        <= '0;
         wdata       <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  write <= cmd_write;
                  addr  <= cmd_addr;
                  wdata <= cmd_wdata;
                  sel   <= 1'b1;
                  en    <= 1'b0;
                  state <= SETUP;
               end
            end
            SETUP: begin
               en    <= 1'b1;
               cnt   <= '0;
               state <= ACCESS;
            end
            ACCESS: begin
               // ready is checked first so a completion on the limit cycle
               // is treated as normal rather than as a timeout.
               if (ready) begin
                  rsp_rdata   <= write ? '0 : rdata;
                  rsp_err     <= slv_err;
                  rsp_timeout <= 1'b0;
                  rsp_valid   <= 1'b1;
                  sel         <= 1'b0;
                  en          <= 1'b0;
                  state       <= RESP;
               end else if (cnt == CNT_LAST) begin
                  rsp_rdata   <= '0;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= 1'b1;
                  sel         <= 1'b0;
                  en          <= 1'b0;
                  state       <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               // Always return through IDLE so sel stays low for at least
               // two cycles between transfers.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               sel   <= 1'b0;
               en    <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
